// File: rtl/piso_pkg.sv
// Shared types and defaults for the piso_tx parallel-in, serial-out transmitter.
package piso_pkg;

  localparam int PISO_DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_e;

endpackage

// File: rtl/piso_shreg.sv
// Load/right-shift data register for piso_tx; bit 0 is the serial output.
module piso_shreg
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             shift_en_i,
  input  logic [WIDTH-1:0] load_data_i,
  output logic             sout_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Zero fill means the register is empty again after WIDTH shifts, so sout
  // drops to 0 on its own when a word finishes without a follow-on load.
  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = load_data_i;
    end else if (shift_en_i) begin
      data_d = {1'b0, data_q[WIDTH-1:1]};
    end
  end

  // NOTE: state is updated with non-blocking assignments and cleared by the
  // asynchronous reset; next-state logic stays in the always_comb above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign sout_o = data_q[0];

endmodule

// File: rtl/piso_tx.sv
// Parallel-in, serial-out transmitter: valid/ready word intake, LSB-first
// serial output with sof/eof framing, back-to-back words and a shift stall.
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             tx_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             sof,
  output logic             eof,
  output logic             busy
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(WIDTH - 1);

  piso_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             sout_valid_q;
  logic             sof_q;
  logic             eof_q;
  logic             busy_q;

  logic at_last;
  logic advance;
  logic accept;

  assign at_last  = (state_q == SHIFT) && (cnt_q == LAST_IDX);
  assign advance  = (state_q == SHIFT) && tx_en;
  // Ready in the last bit slot lets the next word follow with no idle cycle.
  assign in_ready = (state_q == IDLE) || (at_last && tx_en);
  assign accept   = in_valid && in_ready;
  assign cnt_d    = cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sout_valid_q <= 1'b0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else if (accept) begin
      state_q      <= SHIFT;
      cnt_q        <= '0;
      sout_valid_q <= 1'b1;
      sof_q        <= 1'b1;
      eof_q        <= 1'b0;
      busy_q       <= 1'b1;
    end else if (advance) begin
      if (at_last) begin
        state_q      <= IDLE;
        cnt_q        <= '0;
        sout_valid_q <= 1'b0;
        sof_q        <= 1'b0;
        eof_q        <= 1'b0;
        busy_q       <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        sof_q <= 1'b0;
        eof_q <= (cnt_d == LAST_IDX);
      end
    end
  end

  // A load on accept wins over the shift of the word that is just ending.
  piso_shreg #(
    .WIDTH(WIDTH)
  ) u_shreg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (accept),
    .shift_en_i (advance),
    .load_data_i(in_data),
    .sout_o     (sout)
  );

  assign sout_valid = sout_valid_q;
  assign sof        = sof_q;
  assign eof        = eof_q;
  assign busy       = busy_q;

endmodule
